// File: rtl/wb_trace_buf_if.sv
// Write-back trace capture bundle: debug_wb_* event inputs, control strobes,
// the FWFT trace head with its valid/ready handshake, and occupancy/drop statistics.
interface wb_trace_buf_if #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              capture_en;
    logic              clear;
    logic [31:0]       debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;

    logic              trace_valid;
    logic              trace_ready;
    logic [72:0]       trace_data;
    logic [CNT_W-1:0]  trace_count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    // Producer/consumer side of the buffer.
    modport master (
        output capture_en, clear,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output trace_ready,
        input  trace_valid, trace_data, trace_count, overflow, drop_cnt
    );

    // The trace buffer itself.
    modport slave (
        input  capture_en, clear,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  trace_ready,
        output trace_valid, trace_data, trace_count, overflow, drop_cnt
    );
endinterface

// File: rtl/wb_trace_buf.sv
// Circular trace buffer of write-back register events; FWFT head valid one cycle after push.
// Full buffer refuses new events (counted as drops) unless the head is popped the same cycle.
module wb_trace_buf #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    wb_trace_buf_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_cnt;

    entry_t              w_entry;
    logic                w_event;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_entry = '{pc:    bus.debug_wb_pc,
                       wen:   bus.debug_wb_rf_wen,
                       wnum:  bus.debug_wb_rf_wnum,
                       wdata: bus.debug_wb_rf_wdata};

    // Writes to r0 or with no byte enables carry no architectural state.
    assign w_event = bus.capture_en && (bus.debug_wb_rf_wen != 4'b0000)
                     && (bus.debug_wb_rf_wnum != 5'd0);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !bus.clear && !w_empty && bus.trace_ready;
    assign w_push  = !bus.clear && w_event && (!w_full || w_pop);
    assign w_drop  = !bus.clear && w_event && w_full && !w_pop;

    // Storage is deliberately unreset; it is only visible while r_count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.trace_valid = !w_empty;
    assign bus.trace_data  = r_mem[r_rptr];
    assign bus.trace_count = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_wb_trace_buf.sv
// Bench for wb_trace_buf: queue-based reference model checked every negedge, plus directed literal checks.
module tb_wb_trace_buf;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic clk;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    wb_trace_buf_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    wb_trace_buf #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of entries, saturating drop count, sticky overflow.
    logic [72:0] mq[$];
    int          m_drop;
    bit          m_ovf;

    initial begin
        m_drop = 0;
        m_ovf  = 0;
        forever begin
            bit ev;
            bit full;
            bit pop;
            @(posedge clk or negedge resetn);
            if (!resetn || bus.clear) begin
                mq.delete();
                m_drop = 0;
                m_ovf  = 0;
            end else begin
                ev   = bus.capture_en && (bus.debug_wb_rf_wen != 0) && (bus.debug_wb_rf_wnum != 0);
                full = (mq.size() == DEPTH);
                pop  = (mq.size() > 0) && bus.trace_ready;
                if (pop) void'(mq.pop_front());
                if (ev) begin
                    if (!full || pop) begin
                        mq.push_back({bus.debug_wb_pc, bus.debug_wb_rf_wen,
                                      bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata});
                    end else begin
                        m_ovf = 1;
                        if (m_drop < (1 << DROP_W) - 1) m_drop++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_valid", 73'(bus.trace_valid), 73'(mq.size() != 0));
            chk("m_count", 73'(bus.trace_count), 73'(mq.size()));
            chk("m_ovf",   73'(bus.overflow),    73'(m_ovf));
            chk("m_drop",  73'(bus.drop_cnt),    73'(m_drop));
            if (mq.size() != 0) chk("m_data", bus.trace_data, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev_set(input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wd);
        bus.capture_en        = 1'b1;
        bus.debug_wb_pc       = pc;
        bus.debug_wb_rf_wen   = wen;
        bus.debug_wb_rf_wnum  = wnum;
        bus.debug_wb_rf_wdata = wd;
    endtask

    task automatic idle();
        bus.capture_en        = 1'b0;
        bus.debug_wb_rf_wen   = 4'h0;
        bus.debug_wb_rf_wnum  = 5'd0;
    endtask

    initial begin
        resetn                = 1'b0;
        bus.clear             = 1'b0;
        bus.trace_ready       = 1'b0;
        bus.debug_wb_pc       = 32'h0;
        bus.debug_wb_rf_wdata = 32'h0;
        idle();
        repeat (3) tick();
        chk("rst_valid", 73'(bus.trace_valid), 73'(0));
        chk("rst_count", 73'(bus.trace_count), 73'(0));
        chk("rst_drop",  73'(bus.drop_cnt),    73'(0));

        // Single event; pushed on the first edge after reset release.
        resetn = 1'b1;
        ev_set(32'hBFC00000, 4'hF, 5'd2, 32'h1234);
        tick();
        idle();
        chk("single_valid", 73'(bus.trace_valid), 73'(1));
        chk("single_data",  bus.trace_data, {32'hBFC00000, 4'hF, 5'd2, 32'h00001234});
        chk("single_count", 73'(bus.trace_count), 73'(1));
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
        chk("single_drained", 73'(bus.trace_count), 73'(0));

        // Filtering.
        ev_set(32'h100, 4'hF, 5'd0, 32'h1);
        tick();
        ev_set(32'h104, 4'h0, 5'd5, 32'h2);
        tick();
        idle();
        chk("filt_count", 73'(bus.trace_count), 73'(0));
        chk("filt_drop",  73'(bus.drop_cnt),    73'(0));

        // Fill and overflow: 18 events, no consumer.
        for (int i = 1; i <= 18; i++) begin
            ev_set(32'(i), 4'hF, 5'((i % 31) + 1), 32'(i * 3));
            tick();
        end
        idle();
        chk("fill_count", 73'(bus.trace_count), 73'(16));
        chk("fill_drop",  73'(bus.drop_cnt),    73'(2));
        chk("fill_ovf",   73'(bus.overflow),    73'(1));
        chk("fill_head",  73'(bus.trace_data[72:41]), 73'(1));

        // Full with simultaneous pop: accepted, head advances.
        bus.trace_ready = 1'b1;
        ev_set(32'd100, 4'h3, 5'd7, 32'hCAFE);
        tick();
        chk("fullpop_count", 73'(bus.trace_count), 73'(16));
        chk("fullpop_drop",  73'(bus.drop_cnt),    73'(2));
        chk("fullpop_head",  73'(bus.trace_data[72:41]), 73'(2));

        // Drain with capture disabled but event-like inputs present.
        bus.capture_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_pc", 73'(bus.trace_data[72:41]), 73'((k < 15) ? k + 2 : 100));
            tick();
        end
        bus.trace_ready = 1'b0;
        chk("drain_count", 73'(bus.trace_count), 73'(0));
        chk("drain_ovf",   73'(bus.overflow),    73'(1));
        chk("drain_drop",  73'(bus.drop_cnt),    73'(2));

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_ovf",  73'(bus.overflow), 73'(0));
        chk("clr_drop", 73'(bus.drop_cnt), 73'(0));

        // Wrap-around with continuous consumer.
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ev_set(32'h1000 + 32'(i), 4'h1 << (i % 4), 5'((i % 31) + 1), 32'hA000 + 32'(i));
            tick();
            chk("wrap_cnt_le1", 73'(bus.trace_count <= 1), 73'(1));
            chk("wrap_head",    73'(bus.trace_data[72:41]), 73'(32'h1000 + i));
        end
        idle();
        tick();
        chk("wrap_empty", 73'(bus.trace_count), 73'(0));
        chk("wrap_drop",  73'(bus.drop_cnt),    73'(0));

        // Clear with 5 entries, a drop recorded and an event present.
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ev_set(32'h2000 + 32'(i), 4'hF, 5'd9, 32'(i));
            tick();
        end
        idle();
        bus.trace_ready = 1'b1;
        repeat (11) tick();
        bus.trace_ready = 1'b0;
        chk("pre_clr_count", 73'(bus.trace_count), 73'(5));
        chk("pre_clr_drop",  73'(bus.drop_cnt),    73'(1));
        bus.clear = 1'b1;
        ev_set(32'h3000, 4'hF, 5'd4, 32'h55);
        tick();
        bus.clear = 1'b0;
        idle();
        chk("clr2_count", 73'(bus.trace_count), 73'(0));
        chk("clr2_ovf",   73'(bus.overflow),    73'(0));
        chk("clr2_drop",  73'(bus.drop_cnt),    73'(0));

        // Asynchronous reset pulse between clock edges.
        for (int i = 0; i < 3; i++) begin
            ev_set(32'h4000 + 32'(i), 4'hF, 5'd6, 32'(i));
            tick();
        end
        idle();
        chk("pre_rst_count", 73'(bus.trace_count), 73'(3));
        #1 resetn = 1'b0;
        #1;
        chk("arst_count", 73'(bus.trace_count), 73'(0));
        chk("arst_valid", 73'(bus.trace_valid), 73'(0));
        #1 resetn = 1'b1;
        ev_set(32'h5000, 4'h8, 5'd31, 32'hFFFF_FFFF);
        tick();
        idle();
        chk("post_rst_count", 73'(bus.trace_count), 73'(1));
        chk("post_rst_data",  bus.trace_data, {32'h00005000, 4'h8, 5'd31, 32'hFFFFFFFF});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
